clock_hms: RTL and testbench

//  Time-of-day keeper; consumer of the 1 Hz enable from the one-second prescaler.

---
 rtl/clock_hms.sv | 200 ++++++++++++++++++++
 tb/tb_clock_hms.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_hms.sv
// ---------------------------------------------------------------------------
// clock_hms : BCD time-of-day keeper (hours:minutes:seconds).
//
// Advances once per en1hz pulse while in RUN. A small mode FSM lets the user
// stop the clock and set the hours and minutes with push-button pulses.
// Every output is registered, so an input pulse shows its effect one cycle
// later.
//
// Ports
//   clk       in   1  system clock
//   n_rst     in   1  asynchronous active-low reset
//   en1hz     in   1  one-cycle 1 Hz enable
//   btn_mode  in   1  one-cycle pulse: advance mode RUN->SET_HR->SET_MIN->STOP
//   btn_inc   in   1  one-cycle pulse: increment the field that is being set
//   clr       in   1  synchronous clear of the time value (mode is kept)
//   hour_bcd  out  8  hours, BCD {tens,ones}
//   min_bcd   out  8  minutes, BCD
//   sec_bcd   out  8  seconds, BCD
//   mode      out  2  0=RUN 1=SET_HR 2=SET_MIN 3=STOP
//   blink     out  1  alternate-second blink while setting a field
//   day_tick  out  1  one-cycle pulse when the day rolls over in RUN
//   pm        out  1  (CLOCK_H12_EN only) afternoon flag
//
// Build option
//   CLOCK_H12_EN : 12-hour display (12,01..11). The pm output is added and
//                  HOUR_MAX is ignored.
// ---------------------------------------------------------------------------
module clock_hms #(
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       clr,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       blink,
`ifdef CLOCK_H12_EN
    output logic       pm,
`endif
    output logic       day_tick
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        STOP    = 2'd3
    } mode_e;

`ifdef CLOCK_H12_EN
    localparam logic [7:0] HOUR_RST = 8'h12;
`else
    localparam logic [7:0] HOUR_RST = 8'h00;
    localparam logic [7:0] HOUR_TOP = 8'((((HOUR_MAX / 10) % 10) << 4) | (HOUR_MAX % 10));
`endif

    // Single-step BCD increment. Wrap points are handled by the caller, so
    // the tens digit never has to overflow past 5 (min/sec) or 2 (hour).
    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    mode_e      r_mode, w_mode_nxt;
    logic [7:0] r_hour, r_min, r_sec;
    logic [7:0] w_hour_nxt, w_min_nxt, w_sec_nxt;
    logic       r_blink, w_blink_nxt;
    logic       r_day_tick, w_day_tick_nxt;
    logic [7:0] w_hour_inc;   // next hour value for both RUN carry and SET_HR
    logic       w_hour_wrap;  // hour is at its last value before wrapping
`ifdef CLOCK_H12_EN
    logic       r_pm, w_pm_nxt;
`endif

    // Hour stepping differs between the two display formats.
`ifdef CLOCK_H12_EN
    assign w_hour_wrap = (r_hour == 8'h12);
    assign w_hour_inc  = w_hour_wrap ? 8'h01 : f_bcd_inc(r_hour);
`else
    assign w_hour_wrap = (r_hour == HOUR_TOP);
    assign w_hour_inc  = w_hour_wrap ? 8'h00 : f_bcd_inc(r_hour);
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_mode     <= RUN;
            r_hour     <= HOUR_RST;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_blink    <= 1'b0;
            r_day_tick <= 1'b0;
`ifdef CLOCK_H12_EN
            r_pm       <= 1'b0;
`endif
        end else begin
            r_mode     <= w_mode_nxt;
            r_hour     <= w_hour_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_blink    <= w_blink_nxt;
            r_day_tick <= w_day_tick_nxt;
`ifdef CLOCK_H12_EN
            r_pm       <= w_pm_nxt;
`endif
        end
    end

    // Next-state: mode FSM plus time datapath
    always_comb begin
        w_mode_nxt     = r_mode;
        w_hour_nxt     = r_hour;
        w_min_nxt      = r_min;
        w_sec_nxt      = r_sec;
        w_blink_nxt    = r_blink;
        w_day_tick_nxt = 1'b0;
`ifdef CLOCK_H12_EN
        w_pm_nxt       = r_pm;
`endif

        if (btn_mode) begin
            case (r_mode)
                RUN:     w_mode_nxt = SET_HR;
                SET_HR:  w_mode_nxt = SET_MIN;
                SET_MIN: w_mode_nxt = STOP;
                default: w_mode_nxt = RUN;
            endcase
        end

        if (clr) begin
            // clr beats en1hz/btn_inc; the mode still advances above.
            w_hour_nxt = HOUR_RST;
            w_min_nxt  = 8'h00;
            w_sec_nxt  = 8'h00;
`ifdef CLOCK_H12_EN
            w_pm_nxt   = 1'b0;
`endif
        end else begin
            case (r_mode)
                RUN: begin
                    // The tick still lands when btn_mode arrives in the
                    // same cycle; the SET_HR entry below then zeroes sec.
                    if (en1hz) begin
                        if (r_sec == 8'h59) begin
                            w_sec_nxt = 8'h00;
                            if (r_min == 8'h59) begin
                                w_min_nxt  = 8'h00;
                                w_hour_nxt = w_hour_inc;
`ifdef CLOCK_H12_EN
                                // 11:59:59 -> 12:00:00 flips am/pm; pm 1->0 is midnight
                                if (r_hour == 8'h11) begin
                                    w_pm_nxt       = ~r_pm;
                                    w_day_tick_nxt = r_pm;
                                end
`else
                                w_day_tick_nxt = w_hour_wrap;
`endif
                            end else begin
                                w_min_nxt = f_bcd_inc(r_min);
                            end
                        end else begin
                            w_sec_nxt = f_bcd_inc(r_sec);
                        end
                    end
                end
                SET_HR: begin
                    if (btn_inc && !btn_mode) w_hour_nxt = w_hour_inc;
                end
                SET_MIN: begin
                    // Minute wraps without carrying into the hour.
                    if (btn_inc && !btn_mode)
                        w_min_nxt = (r_min == 8'h59) ? 8'h00 : f_bcd_inc(r_min);
                end
                default: ;
            endcase
        end

        // Seconds restart from zero when the user starts setting the time.
        if (btn_mode && r_mode == RUN) w_sec_nxt = 8'h00;

        if (btn_mode || r_mode == RUN || r_mode == STOP) w_blink_nxt = 1'b0;
        else if (en1hz)                                  w_blink_nxt = ~r_blink;
    end

    assign hour_bcd = r_hour;
    assign min_bcd  = r_min;
    assign sec_bcd  = r_sec;
    assign mode     = r_mode;
    assign blink    = r_blink;
    assign day_tick = r_day_tick;
`ifdef CLOCK_H12_EN
    assign pm       = r_pm;
`endif

endmodule

// File: tb/tb_clock_hms.sv
// ---------------------------------------------------------------------------
// tb_clock_hms : directed self-checking bench for clock_hms (24-hour build).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// that follows the rising edge which captured them.
// ---------------------------------------------------------------------------
module tb_clock_hms;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       en1hz, btn_mode, btn_inc, clr;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] mode;
    logic       blink, day_tick;

    int checks = 0;
    int errors = 0;

    clock_hms #(.HOUR_MAX(23)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .en1hz    (en1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .clr      (clr),
        .hour_bcd (hour_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .mode     (mode),
        .blink    (blink),
        .day_tick (day_tick)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: drive at a falling edge, release at the next.
    task automatic step(input logic e, input logic m, input logic i, input logic c);
        en1hz = e; btn_mode = m; btn_inc = i; clr = c;
        @(negedge clk);
        en1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; clr = 1'b0;
    endtask

    task automatic pulses(input int n, input logic e, input logic m, input logic i);
        repeat (n) step(e, m, i, 1'b0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        en1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    // From RUN at 00:00:00: set h:m, then return to RUN with sec = 00.
    task automatic set_hm(input int h, input int m);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        pulses(h, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        pulses(m, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
            errors++; $display("FAIL reset_time got %h want 000000", {hour_bcd, min_bcd, sec_bcd});
        end
        checks++;
        if ({mode, blink, day_tick} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got mode=%0d blink=%b tick=%b want 0/0/0", mode, blink, day_tick);
        end
    endtask

    task automatic test_run_count();
        pulses(61, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000101) begin
            errors++; $display("FAIL run61 got %h want 000101", {hour_bcd, min_bcd, sec_bcd});
        end
        checks++;
        if ({mode, day_tick} !== 3'b000) begin
            errors++; $display("FAIL run61_ctrl got mode=%0d tick=%b want 0/0", mode, day_tick);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        set_hm(23, 59);
        checks++;
        if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'd0, 24'h235900}) begin
            errors++; $display("FAIL preload got mode=%0d %h want 0 235900", mode, {hour_bcd, min_bcd, sec_bcd});
        end
        pulses(59, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235959) begin
            errors++; $display("FAIL pre_roll got %h want 235959", {hour_bcd, min_bcd, sec_bcd});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd, day_tick} !== {24'h000000, 1'b1}) begin
            errors++; $display("FAIL rollover got %h tick=%b want 000000 tick=1", {hour_bcd, min_bcd, sec_bcd}, day_tick);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd, day_tick} !== {24'h000000, 1'b0}) begin
            errors++; $display("FAIL tick_width got %h tick=%b want 000000 tick=0", {hour_bcd, min_bcd, sec_bcd}, day_tick);
        end
    endtask

    task automatic test_set_hr();
        do_reset();
        set_hm(10, 20);
        pulses(30, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h102030) begin
            errors++; $display("FAIL at_102030 got %h want 102030", {hour_bcd, min_bcd, sec_bcd});
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({mode, blink, hour_bcd, min_bcd, sec_bcd} !== {2'd1, 1'b0, 24'h102000}) begin
            errors++; $display("FAIL enter_sethr got mode=%0d blink=%b %h want 1 0 102000", mode, blink, {hour_bcd, min_bcd, sec_bcd});
        end
        pulses(3, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h132000) begin
            errors++; $display("FAIL sethr_inc3 got %h want 132000", {hour_bcd, min_bcd, sec_bcd});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({blink, hour_bcd, min_bcd, sec_bcd} !== {1'b1, 24'h132000}) begin
            errors++; $display("FAIL blink_on got blink=%b %h want 1 132000", blink, {hour_bcd, min_bcd, sec_bcd});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({blink, hour_bcd, min_bcd, sec_bcd} !== {1'b0, 24'h132000}) begin
            errors++; $display("FAIL blink_off got blink=%b %h want 0 132000", blink, {hour_bcd, min_bcd, sec_bcd});
        end
        pulses(10, 1'b0, 1'b0, 1'b1);
        checks++;
        if (hour_bcd !== 8'h23) begin
            errors++; $display("FAIL sethr_23 got %h want 23", hour_bcd);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({hour_bcd, min_bcd, day_tick} !== {16'h0020, 1'b0}) begin
            errors++; $display("FAIL sethr_wrap got %h%h tick=%b want 0020 tick=0", hour_bcd, min_bcd, day_tick);
        end
        pulses(7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({blink, hour_bcd} !== {1'b1, 8'h07}) begin
            errors++; $display("FAIL sethr_07 got blink=%b hour=%h want 1 07", blink, hour_bcd);
        end
    endtask

    task automatic test_set_min();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({mode, blink} !== {2'd2, 1'b0}) begin
            errors++; $display("FAIL enter_setmin got mode=%0d blink=%b want 2 0", mode, blink);
        end
        pulses(39, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h075900) begin
            errors++; $display("FAIL setmin_59 got %h want 075900", {hour_bcd, min_bcd, sec_bcd});
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h070000) begin
            errors++; $display("FAIL setmin_wrap got %h want 070000", {hour_bcd, min_bcd, sec_bcd});
        end
        pulses(5, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'd3, 24'h070500}) begin
            errors++; $display("FAIL mode_prio got mode=%0d %h want 3 070500", mode, {hour_bcd, min_bcd, sec_bcd});
        end
    endtask

    task automatic test_stop();
        pulses(5, 1'b1, 1'b0, 1'b0);
        pulses(2, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({mode, blink, hour_bcd, min_bcd, sec_bcd} !== {2'd3, 1'b0, 24'h070500}) begin
            errors++; $display("FAIL stop_frozen got mode=%0d blink=%b %h want 3 0 070500", mode, blink, {hour_bcd, min_bcd, sec_bcd});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'd3, 24'h000000}) begin
            errors++; $display("FAIL stop_clr got mode=%0d %h want 3 000000", mode, {hour_bcd, min_bcd, sec_bcd});
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (mode !== 2'd0) begin
            errors++; $display("FAIL stop_to_run got mode=%0d want 0", mode);
        end
        pulses(59, 1'b1, 1'b0, 1'b0);
        // Tick and mode change together: carry into minutes, then sec zeroed.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'd1, 24'h000100}) begin
            errors++; $display("FAIL tick_and_mode got mode=%0d %h want 1 000100", mode, {hour_bcd, min_bcd, sec_bcd});
        end
        pulses(4, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'd2, 24'h000000}) begin
            errors++; $display("FAIL clr_and_mode got mode=%0d %h want 2 000000", mode, {hour_bcd, min_bcd, sec_bcd});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        pulses(12, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        pulses(34, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({mode, blink, hour_bcd, min_bcd} !== {2'd2, 1'b1, 16'h1234}) begin
            errors++; $display("FAIL pre_reset got mode=%0d blink=%b %h%h want 2 1 1234", mode, blink, hour_bcd, min_bcd);
        end
        // Assert reset between edges; outputs must clear without a clock.
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({mode, blink, day_tick, hour_bcd, min_bcd, sec_bcd} !== {4'b0000, 24'h000000}) begin
            errors++; $display("FAIL async_reset got mode=%0d blink=%b %h want 0 0 000000", mode, blink, {hour_bcd, min_bcd, sec_bcd});
        end
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'd0, 24'h000001}) begin
            errors++; $display("FAIL post_reset_run got mode=%0d %h want 0 000001", mode, {hour_bcd, min_bcd, sec_bcd});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run_count();
        test_rollover();
        test_set_hr();
        test_set_min();
        test_stop();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
